bar_frame_scheduler: RTL and testbench

Collects one set of signed FFT bin samples from the spectrum datapath, converts each to a bar height in pixels, and holds the heights in a shadow bank. The bank is copied to the active outputs only at a vertical-sync falling edge, so the video sync generator never draws a torn frame. Sits between the FFT output stage and video_sync_generator: it drives that block's bar inputs and its `done` input.

---
 rtl/bar_frame_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_bar_frame_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_frame_scheduler.sv
// bar_frame_scheduler
//   Collects one set of signed FFT bin samples and converts each one to a bar
//   height in pixels. The heights are held in a shadow bank. The bank is
//   copied to the active outputs only on a vsync falling edge, so a frame is
//   never drawn half-updated.
//
//   Ports:
//     clk50      in   system clock, all logic on the rising edge
//     rst        in   asynchronous active-high reset
//     bin_valid  in   bin_data valid this cycle
//     bin_ready  out  a sample is accepted this cycle
//     bin_data   in   signed bin sample (DW bits), bin order from bin 0
//     bin_last   in   final sample of a set
//     vsync      in   active-low vertical sync, same clock domain
//     done       out  one-cycle pulse when the active bank is updated
//     f_bus      out  active bar heights, bar k at [16k+15:16k]
//
//   Optional feature: define PEAK_DECAY_EN for peak-hold bars. Each held
//   peak falls by DECAY pixels per frame.
module bar_frame_scheduler #(
    parameter int unsigned NBINS = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned HMAX  = 480,
    parameter int unsigned DECAY = 4
) (
    input  logic                clk50,
    input  logic                rst,
    input  logic                bin_valid,
    output logic                bin_ready,
    input  logic [DW-1:0]       bin_data,
    input  logic                bin_last,
    input  logic                vsync,
    output logic                done,
    output logic [NBINS*16-1:0] f_bus
);

    localparam int unsigned IW = $clog2(NBINS);
    localparam int unsigned MW = DW - 1;
    localparam int unsigned SW = (MW > 16) ? MW : 16;

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_WAIT_VSYNC, S_SWAP} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                ready_q, done_q;
    logic                vsync_q;
    logic [SW-1:0]       shadow_q [NBINS];
    logic [NBINS*16-1:0] f_bus_q;

    logic                xfer;
    logic [MW-1:0]       mag;
    logic [25:0]         prod;
    logic [25:0]         h_raw;
    logic [15:0]         h_clamp;
    logic [15:0]         held;

    assign bin_ready = ready_q;
    assign done      = done_q;
    assign f_bus     = f_bus_q;
    assign xfer      = bin_valid & ready_q;

    // Magnitude. The most negative code has no positive twin and saturates.
    always_comb begin
        if (!bin_data[DW-1])
            mag = bin_data[MW-1:0];
        else if (bin_data[MW-1:0] == '0)
            mag = '1;
        else
            mag = ~bin_data[MW-1:0] + MW'(1);
    end

    always_comb begin
        prod    = 26'(shadow_q[idx_q]) * 26'(HMAX);
        h_raw   = prod >> (DW - 1);
        h_clamp = (h_raw > 26'(HMAX - 1)) ? 16'(HMAX - 1) : h_raw[15:0];
    end

`ifdef PEAK_DECAY_EN
    logic [15:0] peak_q [NBINS];
    logic [15:0] decayed;

    always_comb begin
        decayed = (peak_q[idx_q] > 16'(DECAY)) ? (peak_q[idx_q] - 16'(DECAY)) : '0;
        held    = (h_clamp > decayed) ? h_clamp : decayed;
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NBINS; i++)
                peak_q[IW'(i)] <= '0;
        end else if (state_q == S_CALC) begin
            peak_q[idx_q] <= held;
        end
    end
`else
    logic [15:0] unused_decay;

    assign unused_decay = 16'(DECAY);
    always_comb held = h_clamp;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_LOAD: begin
                if (xfer) begin
                    if (bin_last || idx_q == IW'(NBINS - 1)) begin
                        state_d = S_CALC;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_CALC: begin
                if (idx_q == IW'(NBINS - 1)) begin
                    state_d = S_WAIT_VSYNC;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_WAIT_VSYNC: begin
                if (vsync_q && !vsync)
                    state_d = S_SWAP;
            end
            S_SWAP: begin
                state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // ready/done are registered from the next state so they line up with
    // the state they describe while still reading 0 straight out of reset.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            vsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= (state_d == S_LOAD);
            done_q  <= (state_d == S_SWAP);
            vsync_q <= vsync;
        end
    end

    // Shadow bank holds magnitudes during LOAD and is rewritten in place
    // with bar heights during CALC.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NBINS; i++)
                shadow_q[IW'(i)] <= '0;
            f_bus_q <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (xfer) begin
                        shadow_q[idx_q] <= SW'(mag);
                        // A short set clears the bins it never wrote.
                        if (bin_last) begin
                            for (int unsigned i = 0; i < NBINS; i++)
                                if (i > 32'(idx_q))
                                    shadow_q[IW'(i)] <= '0;
                        end
                    end
                end
                S_CALC: begin
                    shadow_q[idx_q] <= SW'(held);
                end
                S_SWAP: begin
                    for (int unsigned i = 0; i < NBINS; i++)
                        f_bus_q[16*i +: 16] <= shadow_q[IW'(i)][15:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_frame_scheduler.sv
module tb_bar_frame_scheduler;

    localparam int NBINS = 16;
    localparam int DW    = 16;
    localparam int HMAX  = 480;
    localparam int DECAY = 4;

    logic                clk50 = 1'b0;
    logic                rst = 1'b1;
    logic                bin_valid = 1'b0;
    logic                bin_ready;
    logic [DW-1:0]       bin_data = '0;
    logic                bin_last = 1'b0;
    logic                vsync = 1'b1;
    logic                done;
    logic [NBINS*16-1:0] f_bus;

    int checks = 0;
    int errors = 0;

    bar_frame_scheduler #(
        .NBINS(NBINS),
        .DW   (DW),
        .HMAX (HMAX),
        .DECAY(DECAY)
    ) dut (
        .clk50    (clk50),
        .rst      (rst),
        .bin_valid(bin_valid),
        .bin_ready(bin_ready),
        .bin_data (bin_data),
        .bin_last (bin_last),
        .vsync    (vsync),
        .done     (done),
        .f_bus    (f_bus)
    );

    always #10 clk50 = ~clk50;

    // ---------------- behavioural model ----------------
    // The model timestamps the last sample of a set. A vsync falling edge
    // seen at least NBINS+1 cycles after that sample triggers the swap.
    logic                exp_ready = 1'b0;
    logic                exp_done  = 1'b0;
    logic [NBINS*16-1:0] exp_bus   = '0;
    int     m_buf  [NBINS];
    int     m_pend [NBINS];
    int     m_peak [NBINS];
    int     m_nload = 0;
    bit     m_load = 1'b1;
    bit     m_have = 1'b0;
    bit     m_vs_prev = 1'b1;
    longint m_swap_from = 0;
    longint cyc = 0;

    function automatic int magof(input logic [DW-1:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > (1 << (DW - 1)) - 1) v = (1 << (DW - 1)) - 1;
        return v;
    endfunction

    function automatic int height(input int mag);
        longint p;
        p = longint'(mag) * HMAX / (longint'(1) << (DW - 1));
        if (p > HMAX - 1) p = HMAX - 1;
        return int'(p);
    endfunction

    always @(posedge clk50) begin
        longint cur;
        bit nd;
        cur = cyc;
        cyc = cyc + 1;
        if (rst) begin
            exp_ready = 1'b0;
            exp_done  = 1'b0;
            exp_bus   = '0;
            m_nload   = 0;
            m_load    = 1'b1;
            m_have    = 1'b0;
            m_vs_prev = 1'b1;
            for (int k = 0; k < NBINS; k++) begin
                m_buf[k] = 0; m_pend[k] = 0; m_peak[k] = 0;
            end
        end else begin
            nd = 1'b0;
            if (exp_done) begin
                for (int k = 0; k < NBINS; k++) exp_bus[16*k +: 16] = 16'(m_pend[k]);
                m_load = 1'b1;
            end else if (exp_ready && bin_valid) begin
                m_buf[m_nload] = magof(bin_data);
                m_nload++;
                if (bin_last || m_nload == NBINS) begin
                    for (int k = m_nload; k < NBINS; k++) m_buf[k] = 0;
                    for (int k = 0; k < NBINS; k++) begin
                        int h;
                        h = height(m_buf[k]);
`ifdef PEAK_DECAY_EN
                        if (m_peak[k] - DECAY > h) h = m_peak[k] - DECAY;
                        m_peak[k] = h;
`endif
                        m_pend[k] = h;
                    end
                    m_nload     = 0;
                    m_load      = 1'b0;
                    m_have      = 1'b1;
                    m_swap_from = cur + NBINS + 1;
                end
            end else if (m_have && cur >= m_swap_from && m_vs_prev && !vsync) begin
                nd = 1'b1;
                m_have = 1'b0;
            end
            exp_ready = m_load;
            exp_done  = nd;
            m_vs_prev = vsync;
        end
    end

    // ---------------- compare process ----------------
    int     done_cnt = 0;
    longint done_time = 0;

    always @(negedge clk50) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_time = $time;
        end
        if (!rst) begin
            checks++;
            if (bin_ready !== exp_ready) begin
                errors++;
                $display("FAIL cyc_bin_ready t=%0t: got %b expected %b", $time, bin_ready, exp_ready);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL cyc_done t=%0t: got %b expected %b", $time, done, exp_done);
            end
            checks++;
            if (f_bus !== exp_bus) begin
                errors++;
                $display("FAIL cyc_f_bus t=%0t: got %h expected %h", $time, f_bus, exp_bus);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    function automatic int get_bar(input int k);
        return int'(f_bus[16*k +: 16]);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bin_valid = 1'b0;
        bin_last = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_set(input int vals[NBINS], input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            int budget;
            budget = 0;
            bin_valid = 1'b1;
            bin_data  = DW'(vals[i]);
            bin_last  = (i == n - 1);
            while (!bin_ready && budget < 200) begin
                tick();
                budget++;
            end
            if (!bin_ready) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: bin_ready got 0 expected 1 at sample %0d", i);
            end
            tick();
            if (toggle) begin
                bin_valid = 1'b0;
                bin_last  = 1'b0;
                tick();
            end
        end
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    longint te;

    task automatic vsync_pulse();
        vsync = 1'b0;
        te = $time;
        repeat (3) tick();
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    int vals[NBINS];
    int dc0;

    initial begin
        // Reset state and reset during LOAD
        repeat (3) tick();
        chk("rst_bin_ready", bin_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_f_bus_nonzero", (f_bus != '0), 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < NBINS; i++) vals[i] = 5000 + i;
        send_set(vals, 5, 1'b0);
        bin_valid = 1'b1;
        bin_data  = DW'(9999);
        rst = 1'b1;
        tick();
        bin_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("midload_rst_f_bus_nonzero", (f_bus != '0), 0);
        chk("midload_rst_done", done, 0);

        // Full set, one swap 100 cycles later
        vals = '{240, 16383, 32767, -480, -32768, 0, 100, 200,
                 300, 400, 500, 600, 700, 800, 900, 1000};
        dc0 = done_cnt;
        send_set(vals, NBINS, 1'b0);
        chk("t2_ready_after_last", bin_ready, 0);
        repeat (100) tick();
        vsync_pulse();
        chk("t2_done_count", done_cnt - dc0, 1);
        chk("t2_done_latency", done_time - te, 29);
        chk("t2_bar0", get_bar(0), 3);
        chk("t2_bar1", get_bar(1), 239);
        chk("t2_bar2", get_bar(2), 479);
        chk("t2_bar3", get_bar(3), 7);
        chk("t2_bar4", get_bar(4), 479);
        chk("t2_bar5", get_bar(5), 0);
        chk("t2_bar15", get_bar(15), 14);

        // vsync edge during CALC is ignored
        do_reset();
        for (int i = 0; i < NBINS; i++) vals[i] = 2000;
        dc0 = done_cnt;
        send_set(vals, NBINS, 1'b0);
        tick();
        vsync_pulse();
        repeat (30) tick();
        chk("t3_no_done", done_cnt - dc0, 0);
        chk("t3_f_bus_unchanged", (f_bus != '0), 0);
        vsync_pulse();
        chk("t3_done_next_edge", done_cnt - dc0, 1);
        chk("t3_bar0", get_bar(0), 29);
        chk("t3_bar15", get_bar(15), 29);

        // bin_valid toggling every other cycle
        do_reset();
        for (int i = 0; i < NBINS; i++) vals[i] = 2048 * i;
        send_set(vals, NBINS, 1'b1);
        repeat (NBINS + 5) tick();
        vsync_pulse();
        chk("t5_bar1", get_bar(1), 30);
        chk("t5_bar7", get_bar(7), 210);
        chk("t5_bar15", get_bar(15), 450);

        // Short set: bin_last on the 4th sample clears the rest
        for (int i = 0; i < NBINS; i++) vals[i] = 1000;
        send_set(vals, 4, 1'b0);
        repeat (NBINS + 5) tick();
        vsync_pulse();
        for (int k = 0; k < NBINS; k++) begin
            int e;
            e = (k < 4) ? 14 : 0;
`ifdef PEAK_DECAY_EN
            if (30 * k - DECAY > e) e = 30 * k - DECAY;
`endif
            chk($sformatf("t4_bar%0d", k), get_bar(k), e);
        end

        // Peak decay across three frames
        do_reset();
        for (int i = 0; i < NBINS; i++) vals[i] = 0;
        vals[0] = 32767;
        send_set(vals, NBINS, 1'b0);
        repeat (NBINS + 5) tick();
        vsync_pulse();
        chk("t6_frame1_bar0", get_bar(0), 479);
        vals[0] = 0;
        send_set(vals, NBINS, 1'b0);
        repeat (NBINS + 5) tick();
        vsync_pulse();
`ifdef PEAK_DECAY_EN
        chk("t6_frame2_bar0", get_bar(0), 475);
`else
        chk("t6_frame2_bar0", get_bar(0), 0);
`endif
        send_set(vals, NBINS, 1'b0);
        repeat (NBINS + 5) tick();
        vsync_pulse();
`ifdef PEAK_DECAY_EN
        chk("t6_frame3_bar0", get_bar(0), 471);
`else
        chk("t6_frame3_bar0", get_bar(0), 0);
`endif

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
